// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS-style multiply/divide unit with HI/LO registers
module mult_div_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             MDU_i_clk,
   input  logic             MDU_i_rst_n,
   input  logic [WIDTH-1:0] MDU_i_Operand1,
   input  logic [WIDTH-1:0] MDU_i_Operand2,
   input  logic [3:0]       MDU_i_Operation,
   input  logic             MDU_i_Start,
   input  logic             MDU_i_Cancel,
   output logic [WIDTH-1:0] MDU_o_HI,
   output logic [WIDTH-1:0] MDU_o_LO,
   output logic             MDU_o_Busy,
   output logic             MDU_o_Done,
   output logic             MDU_o_DivByZero
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] a, b, ua, ub, uq, ur, q, r, res_hi, res_lo;
   logic [1:0] op;
   logic [2*WIDTH-1:0] prod;
   logic accept, finish, wr_hi, wr_lo, sgn, na, nb, div_zero;
   // Bit 0 of the latched op selects unsigned; bit 1 selects divide.
   assign sgn      = ~op[0];
   assign na       = sgn & a[WIDTH-1];
   assign nb       = sgn & b[WIDTH-1];
   assign div_zero = op[1] && (b == '0);
   // Signed division is done on magnitudes so the most-negative / -1 case wraps cleanly.
   always_comb begin
      prod   = {{WIDTH{na}}, a} * {{WIDTH{nb}}, b};
      ua     = na ? -a : a;
      ub     = nb ? -b : b;
      uq     = div_zero ? '0 : ua / ub;
      ur     = div_zero ? '0 : ua % ub;
      q      = (na ^ nb) ? -uq : uq;
      r      = na ? -ur : ur;
      res_hi = op[1] ? r : prod[2*WIDTH-1:WIDTH];
      res_lo = op[1] ? q : prod[WIDTH-1:0];
   end
   // Next-state and acceptance decode; cancel always beats start and completion.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      finish   = 1'b0;
      wr_hi    = 1'b0;
      wr_lo    = 1'b0;
      if (state == IDLE) begin
         accept   = MDU_i_Start && !MDU_i_Cancel && (MDU_i_Operation < 4'd4);
         wr_hi    = MDU_i_Start && !MDU_i_Cancel && (MDU_i_Operation == 4'd4);
         wr_lo    = MDU_i_Start && !MDU_i_Cancel && (MDU_i_Operation == 4'd5);
         state_nx = accept ? RUN : IDLE;
      end else if (MDU_i_Cancel) begin
         state_nx = IDLE;
      end else if (cnt == CW'(1)) begin
         state_nx = IDLE;
         finish   = 1'b1;
      end
   end
   // State register.
   always_ff @(posedge MDU_i_clk) begin
      if (!MDU_i_rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // Operand latch, latency counter, HI/LO and completion pulses.
   always_ff @(posedge MDU_i_clk) begin
      if (!MDU_i_rst_n) begin
         a               <= '0;
         b               <= '0;
         op              <= '0;
         cnt             <= '0;
         MDU_o_HI        <= '0;
         MDU_o_LO        <= '0;
         MDU_o_Done      <= 1'b0;
         MDU_o_DivByZero <= 1'b0;
      end else begin
         MDU_o_Done      <= finish;
         MDU_o_DivByZero <= finish && div_zero;
         if (accept) begin
            a   <= MDU_i_Operand1;
            b   <= MDU_i_Operand2;
            op  <= MDU_i_Operation[1:0];
            cnt <= MDU_i_Operation[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
         end else if (state == RUN) begin
            cnt <= (MDU_i_Cancel || finish) ? '0 : cnt - CW'(1);
         end
         if (finish && !div_zero) begin
            MDU_o_HI <= res_hi;
            MDU_o_LO <= res_lo;
         end
         if (wr_hi) MDU_o_HI <= MDU_i_Operand1;
         if (wr_lo) MDU_o_LO <= MDU_i_Operand1;
      end
   end
   assign MDU_o_Busy = (state == RUN);
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, random model comparison and corner-case sequences
module tb_mult_div_unit;
   localparam int MC = 5;
   localparam int DC = 10;
   logic clk = 0, rst_n = 0, start = 0, cancel = 0;
   logic [31:0] op1 = 0, op2 = 0;
   logic [3:0] opc = 0;
   logic [31:0] hi, lo;
   logic busy, done, dbz;
   logic [31:0] mhi, mlo;
   int tests = 0, fails = 0;
   mult_div_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .MDU_i_clk(clk), .MDU_i_rst_n(rst_n), .MDU_i_Operand1(op1), .MDU_i_Operand2(op2),
      .MDU_i_Operation(opc), .MDU_i_Start(start), .MDU_i_Cancel(cancel),
      .MDU_o_HI(hi), .MDU_o_LO(lo), .MDU_o_Busy(busy), .MDU_o_Done(done),
      .MDU_o_DivByZero(dbz)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   // Reference: 64-bit arithmetic straight from the operation definitions.
   task automatic ref_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output bit dz);
      longint sa, sb, rs;
      longint unsigned ua, ub, ru;
      sa = $signed(a); sb = $signed(b); ua = a; ub = b;
      lat = 0; dz = 0;
      case (op)
         4'd0: begin rs = sa * sb; mhi = rs[63:32]; mlo = rs[31:0]; lat = MC; end
         4'd1: begin ru = ua * ub; mhi = ru[63:32]; mlo = ru[31:0]; lat = MC; end
         4'd2: begin
            lat = DC;
            if (b == 0) dz = 1;
            else begin rs = sa / sb; mlo = rs[31:0]; rs = sa % sb; mhi = rs[31:0]; end
         end
         4'd3: begin
            lat = DC;
            if (b == 0) dz = 1;
            else begin ru = ua / ub; mlo = ru[31:0]; ru = ua % ub; mhi = ru[31:0]; end
         end
         4'd4: mhi = a;
         4'd5: mlo = a;
         default: ;
      endcase
   endtask
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int lat, n;
      bit dz, early;
      @(negedge clk);
      opc = op; op1 = a; op2 = b; start = 1;
      ref_apply(op, a, b, lat, dz);
      @(negedge clk);
      start = 0; op1 = $urandom; op2 = $urandom;
      n = 0; early = 0;
      while (busy && n < 40) begin
         if (done) early = 1;
         n++;
         @(negedge clk);
      end
      chk($sformatf("latency op%0d", op), n, lat);
      chk("early_done", early, 0);
      chk("done", done, lat != 0);
      chk("divbyzero", dbz, dz);
      chk("hi", hi, mhi);
      chk("lo", lo, mlo);
      @(negedge clk);
      chk("done_pulse", done, 0);
   endtask
   typedef struct {logic [3:0] op; logic [31:0] a, b, hi, lo;} vec_t;
   vec_t vecs[6];
   initial begin
      int seen;
      logic [3:0] rop;
      logic [31:0] ra, rb;
      vecs[0] = '{4'd0, 32'd7, 32'd1234567, 32'h0, 32'h0083DDB1};
      vecs[1] = '{4'd0, 32'd11, 32'hFFFFF85C, 32'hFFFFFFFF, 32'hFFFFABF4};
      vecs[2] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
      vecs[3] = '{4'd2, 32'hFFFFF85C, 32'd11, 32'hFFFFFFF7, 32'hFFFFFF4F};
      vecs[4] = '{4'd3, 32'hFFFFF85C, 32'd11, 32'd6, 32'd390451394};
      vecs[5] = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
      mhi = 0; mlo = 0;
      repeat (3) @(negedge clk);
      chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dbz", dbz, 0);
      rst_n = 1;
      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b);
         chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
         chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      end
      // Divide by zero keeps preset HI/LO.
      do_op(4'd4, 32'h12345678, 0);
      do_op(4'd5, 32'h12345678, 0);
      do_op(4'd2, 32'd99, 32'd0);
      chk("dz_hi", hi, 32'h12345678); chk("dz_lo", lo, 32'h12345678);
      // Divide, ignored second start while busy, cancel at busy cycle 4.
      @(negedge clk); opc = 2; op1 = 100; op2 = 7; start = 1;
      @(negedge clk); start = 0; chk("cx_busy", busy, 1);
      @(negedge clk); opc = 0; op1 = 3; op2 = 3; start = 1;
      @(negedge clk); start = 0;
      @(negedge clk); cancel = 1;
      @(negedge clk); cancel = 0;
      chk("cx_idle", busy, 0); chk("cx_done", done, 0);
      seen = 0;
      repeat (12) begin @(negedge clk); if (done || busy) seen = 1; end
      chk("cx_quiet", seen, 0); chk("cx_hi", hi, mhi); chk("cx_lo", lo, mlo);
      // Cancel together with start in IDLE: nothing accepted.
      @(negedge clk); opc = 0; op1 = 5; op2 = 5; start = 1; cancel = 1;
      @(negedge clk); chk("cs_busy", busy, 0); opc = 5;
      @(negedge clk); start = 0; cancel = 0;
      chk("cs_lo", lo, mlo); chk("cs_hi", hi, mhi);
      // Cancel on the completing edge.
      @(negedge clk); opc = 0; op1 = 3; op2 = 3; start = 1;
      @(negedge clk); start = 0;
      repeat (MC - 1) @(negedge clk);
      chk("ce_busy", busy, 1);
      cancel = 1;
      @(negedge clk); cancel = 0;
      chk("ce_idle", busy, 0); chk("ce_done", done, 0);
      chk("ce_hi", hi, mhi); chk("ce_lo", lo, mlo);
      // Reset in the middle of a multiply.
      do_op(4'd4, 32'hAAAA5555, 0);
      @(negedge clk); opc = 0; op1 = 7; op2 = 9; start = 1;
      @(negedge clk); start = 0;
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      chk("rm_hi", hi, 0); chk("rm_lo", lo, 0); chk("rm_busy", busy, 0); chk("rm_done", done, 0);
      mhi = 0; mlo = 0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (done || busy) seen = 1; end
      chk("rm_quiet", seen, 0);
      do_op(4'd5, 32'hDEADBEEF, 0);
      chk("rm_mtlo", lo, 32'hDEADBEEF);
      // Randomised operations against the reference.
      repeat (40) begin
         rop = 4'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) rop = 4'd15;
         ra = $urandom; rb = $urandom;
         if ($urandom_range(0, 5) == 0) rb = 0;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 300));
         do_op(rop, ra, rb);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and HI/LO width.
REQ-002 Parameter MULT_CYCLES, default 5, SHALL set multiply latency in cycles (>=1).
REQ-003 Parameter DIV_CYCLES, default 10, SHALL set divide latency in cycles (>=1).
REQ-004 MDU_i_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 MDU_i_rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-006 MDU_i_Operand1  in  WIDTH  SHALL carry rs value (multiplicand / dividend / MTHI-MTLO source).
REQ-007 MDU_i_Operand2  in  WIDTH  SHALL carry rt value (multiplier / divisor).
REQ-008 MDU_i_Operation  in  4  SHALL select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-15 no-op.
REQ-009 MDU_i_Start  in  1  SHALL request execution of MDU_i_Operation in the current cycle.
REQ-010 MDU_i_Cancel  in  1  SHALL abort an in-flight operation (pipeline flush).
REQ-011 MDU_o_HI  out  WIDTH  SHALL present the HI register.
REQ-012 MDU_o_LO  out  WIDTH  SHALL present the LO register.
REQ-013 MDU_o_Busy  out  1  SHALL be high while a multi-cycle operation is in flight.
REQ-014 MDU_o_Done  out  1  SHALL pulse high for one cycle when HI/LO receive a multi-cycle result.
REQ-015 MDU_o_DivByZero  out  1  SHALL pulse high with Done when a DIV/DIVU had divisor 0.

Function
REQ-016 States SHALL be IDLE and RUN; Busy = (state == RUN), registered.
REQ-017 Start SHALL be accepted only in IDLE with Cancel low; Start in RUN SHALL be ignored (no queueing).
REQ-018 Accepted ops 0-3 SHALL latch operands and op, load counter with MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3), enter RUN.
REQ-019 Busy SHALL be high for exactly N cycles following the accepting edge (N = op latency).
REQ-020 On the Nth edge after acceptance HI/LO SHALL update, state SHALL return to IDLE, Done SHALL be high the following cycle only.
REQ-021 Accepted MTHI/MTLO SHALL write Operand1 to HI/LO at that edge, no Busy, no Done.
REQ-022 Accepted ops 6-15 SHALL change nothing.
REQ-023 MULT/MULTU SHALL form the 2*WIDTH signed/unsigned product; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-024 DIV/DIVU SHALL give LO = quotient truncated toward zero, HI = remainder with dividend's sign (signed/unsigned per op).
REQ-025 Signed DIV of most-negative by -1 SHALL give LO = most-negative, HI = 0, no flag.
REQ-026 Divisor 0 SHALL leave HI/LO unchanged, still take DIV_CYCLES, and assert DivByZero with Done.
REQ-027 Operand changes after acceptance SHALL NOT affect the result.
REQ-028 Cancel high in RUN SHALL return to IDLE at the next edge, HI/LO unchanged, no Done.
REQ-029 Cancel and Start high together in IDLE SHALL cancel; the op SHALL NOT be accepted.
REQ-030 Cancel on the completing edge SHALL win; HI/LO SHALL NOT update.
REQ-031 HI/LO outputs SHALL be registered and change only per REQ-020/021, reset.

Reset
REQ-032 With rst_n low at an edge: HI = 0, LO = 0, state IDLE, counter 0, Busy = Done = DivByZero = 0.
REQ-033 Reset SHALL override Start and Cancel and abort any in-flight operation without HI/LO update.

Verification
REQ-034 MULT 7 x 1234567 (defaults) -> Busy high 5 cycles, then HI=0x00000000, LO=0x0083DDB1, Done 1 cycle.
REQ-035 MULT 11 x -1956 -> HI=0xFFFFFFFF, LO=0xFFFFABF4; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV -1956 / 11 -> after 10 Busy cycles LO=0xFFFFFF4F (-177), HI=0xFFFFFFF7 (-9); DIVU same operands -> LO=390451394, HI=6.
REQ-037 DIV x / 0 with HI=LO=0x12345678 preset via MTHI/MTLO -> HI/LO unchanged, Done and DivByZero high same cycle; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
REQ-038 Start DIV, Cancel at Busy cycle 4, Start second op while Busy -> IDLE next edge, no Done, HI/LO unchanged, second op ignored.
REQ-039 rst_n low mid-MULT -> next cycle HI=LO=0, Busy=0, no Done; MTLO 0xDEADBEEF after -> LO=0xDEADBEEF next cycle, Busy stays 0.
